alu_decode_md: RTL and testbench
================================

Name: alu_decode_md

Overview:
- Parametrised successor to the EX-stage ALU control decoder for the pipelined RV32 core.
- Decodes ALUOp/opcode/fn3/fn7 into a wider ALU control code covering all RV32I ALU and branch-compare operations.
- Also detects RV32M ops and runs them on an iterative multiply/divide engine, stalling the pipeline until the result is ready.
- Sits in EX beside the ALU; the stall output feeds the hazard unit.

Parameters:
- WIDTH, 32, operand/result width; must be even and at least 8.
- STEPS, 1, shift-add/subtract iterations per clock; 1, 2 or 4; must divide WIDTH.
- CTRL_W, 4, width of alu_ctrl; must be at least 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ALUOp  in  2  main-decoder class: 00 add (load/store/auipc), 01 branch, 10 R/I arithmetic, 11 pass B (lui)
- opcode  in  7  instruction opcode; only bit 5 is used (1 = R-type)
- fn3  in  3  funct3
- fn7  in  7  funct7
- ex_valid  in  1  EX holds a valid instruction
- flush  in  1  kill the EX instruction (branch taken / trap)
- src_a  in  WIDTH  rs1 operand
- src_b  in  WIDTH  rs2 operand
- alu_ctrl  out  CTRL_W  ALU operation code, from alu_pkg
- is_md  out  1  current instruction is RV32M
- stall  out  1  hold IF/ID/EX; M op in progress
- md_done  out  1  one-cycle pulse; md_result valid
- md_result  out  WIDTH  M-op result, held until the next accept

Behaviour:
- Decode is combinational, with zero latency.
  - ALUOp 00: ADD.
  - ALUOp 11: PASSB.
  - ALUOp 01, by fn3: beq/bne SUB, blt/bge SLT, bltu/bgeu SLTU; others ADD.
  - ALUOp 10, by fn3: 000 ADD, or SUB when opcode[5]=1 and fn7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when fn7[5]=1 (for I and R types); 110 OR; 111 AND.
- is_md = ALUOp==10, opcode[5]==1 and fn7==0000001. When is_md is set, alu_ctrl = ADD (don't-care) and fn3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- FSM states are IDLE, CALC and DONE.
  - IDLE to CALC: on accept = ex_valid & is_md & !flush. Accept latches operands as magnitudes plus sign flags, the op, and count = WIDTH/STEPS.
  - CALC: count decrements each cycle. Go to DONE when count reaches 1 and the final STEPS iterations complete that cycle.
  - DONE: drive md_done=1 with the sign-fixed md_result, then return to IDLE.
- stall = accept | (state==CALC). The stall is combinational in the accept cycle and is 0 in DONE, so the pipeline advances.
- Latency is 1 + WIDTH/STEPS stalled cycles, then the DONE cycle. WIDTH=32, STEPS=1 gives 33 stalled cycles with md_done in cycle 34.
- Multiply uses a 2*WIDTH shift-add on magnitudes.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half, after two's-complement negation when the signs differ (MULHSU treats src_b as unsigned).
- Divide uses restoring division on magnitudes; the quotient is negated when the signs differ and the remainder takes the dividend's sign.
  - Divide by zero: quotient all-ones, remainder = dividend. Skip iteration and go straight from IDLE to DONE with a 1-cycle stall.
  - Signed overflow (most-negative / -1): quotient = most-negative, remainder 0. Also handled by the DONE shortcut.
- flush in CALC or DONE: go to IDLE next cycle. No md_done, stall drops the same cycle, md_result is unchanged.
- flush together with ex_valid&is_md in IDLE: no accept, stall=0.
- Back-to-back M ops: the next op can be accepted in the IDLE cycle right after DONE.
- rst: state IDLE, count 0, md_result 0, md_done 0. While rst is high, stall is forced to 0. A rst during CALC aborts the op with no md_done.

Decomposition:
- alu_pkg holds:
  - alu_ctrl_e: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SLT 5, SLTU 6, XOR 7, SRL 8, SRA 9, PASSB 10.
  - ALUOp constants.
  - md_op_e, indexed by fn3.
  - FN7_MULDIV = 7'b0000001.
- One sub-module, md_iter_core, holds the FSM, counter and datapath. The top module holds the decode logic and the stall/accept glue.

Test Plan:
- Decode sweep, ALUOp=10, opcode[5]=1, fn7=0100000: fn3=000 gives SUB, fn3=101 gives SRA. ALUOp=01, fn3=110 gives SLTU. ALUOp=11 gives PASSB. No stall in any case.
- MUL, src_a=7, src_b=-3, WIDTH=32, STEPS=1: stall high 33 cycles, then md_done with md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF. DIVU 100/0 gives 0xFFFFFFFF after a 1-cycle stall; REM 0x80000000 / -1 gives 0.
- flush asserted 10 cycles into a DIV: stall drops that cycle, no md_done, FSM returns to IDLE. The next MUL 3*4 then gives 12.
- Back-to-back MUL 5*6 then DIVU 30/4: results 30 then 7, with exactly one IDLE cycle and stall low between them.
- rst asserted mid-CALC: all outputs 0 next cycle. Repeat the MUL and DIV cases with STEPS=4: stall high 9 cycles, same results.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, ALUOp classes and RV32M op encodings for the EX stage.
// Rev 1.0
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLL   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_PASSB  = 2'b11;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  localparam logic [6:0] FN7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_iter_core.sv
// md_iter_core: iterative RV32M engine (shift-add multiply, restoring divide) with its FSM.
// Rev 1.0
`default_nettype none

module md_iter_core #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  alu_pkg::md_op_e         op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic                    idle,
  output logic                    calc,
  output logic                    done,
  output logic [WIDTH-1:0]        result
);
  import alu_pkg::*;

  localparam int ITERS = WIDTH / STEPS;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e         state, state_nx;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  hi, lo, bmag, held;
  md_op_e            op_q;
  logic              neg_q, neg_r;

  logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, shortcut;
  logic [WIDTH-1:0]  a_abs, b_abs;

  always_comb begin
    a_signed = op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    a_neg    = a_signed & a[WIDTH-1];
    b_neg    = b_signed & b[WIDTH-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    div_zero = (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && (b == '0);
    div_ovf  = (op inside {MD_DIV, MD_REM}) && (a == MOST_NEG) && (b == '1);
    shortcut = div_zero | div_ovf;
  end

  // hi holds the running product high half / partial remainder, lo the multiplier / quotient
  logic [WIDTH-1:0] hi_it, lo_it;
  logic [WIDTH:0]   trial, sum;

  always_comb begin
    hi_it = hi;
    lo_it = lo;
    trial = '0;
    sum   = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
        trial = {hi_it, lo_it[WIDTH-1]};
        if (trial >= {1'b0, bmag}) begin
          hi_it = trial[WIDTH-1:0] - bmag;
          lo_it = {lo_it[WIDTH-2:0], 1'b1};
        end else begin
          hi_it = trial[WIDTH-1:0];
          lo_it = {lo_it[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum            = {1'b0, hi_it} + (lo_it[0] ? {1'b0, bmag} : '0);
        {hi_it, lo_it} = {sum, lo_it[WIDTH-1:1]};
      end
    end
  end

  logic [WIDTH-1:0] q_fix, h_fix, r_fix, res_fix;

  always_comb begin
    q_fix = neg_q ? -lo : lo;
    h_fix = neg_q ? (~hi + WIDTH'(lo == '0)) : hi;
    r_fix = neg_r ? -hi : hi;
    case (op_q)
      MD_MUL, MD_DIV, MD_DIVU:        res_fix = q_fix;
      MD_MULH, MD_MULHSU, MD_MULHU:   res_fix = h_fix;
      default:                        res_fix = r_fix;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = shortcut ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)                        state_nx = ST_IDLE;
        else if (count == CNT_W'(1))      state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      bmag  <= '0;
      held  <= '0;
      op_q  <= MD_MUL;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        op_q  <= op;
        count <= CNT_W'(ITERS);
        bmag  <= b_abs;
        if (shortcut) begin
          // final values preloaded; the DONE cycle only selects between them
          hi    <= div_zero ? a : '0;
          lo    <= div_zero ? '1 : MOST_NEG;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          hi    <= '0;
          lo    <= a_abs;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if (state == ST_CALC && !flush) begin
        hi    <= hi_it;
        lo    <= lo_it;
        count <= count - CNT_W'(1);
      end
      if (state == ST_DONE && !flush) held <= res_fix;
    end
  end

  assign idle   = (state == ST_IDLE);
  assign calc   = (state == ST_CALC);
  assign done   = (state == ST_DONE) & ~flush & ~rst;
  assign result = done ? res_fix : held;

endmodule

`default_nettype wire

// File: rtl/alu_decode_md.sv
// alu_decode_md: EX-stage ALU control decoder with RV32M detection and pipeline stall glue.
// Rev 1.0
`default_nettype none

module alu_decode_md #(
  parameter int WIDTH  = 32,
  parameter int STEPS  = 1,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        opcode,
  input  logic [2:0]        fn3,
  input  logic [6:0]        fn7,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              is_md,
  output logic              stall,
  output logic              md_done,
  output logic [WIDTH-1:0]  md_result
);
  import alu_pkg::*;

  alu_ctrl_e ctrl;
  logic      core_idle, core_calc, accept;
  logic      unused_opcode;

  assign unused_opcode = ^{opcode[6], opcode[4:0]};
  assign is_md = (ALUOp == ALUOP_ARITH) && opcode[5] && (fn7 == FN7_MULDIV);

  always_comb begin
    ctrl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD:   ctrl = ALU_ADD;
      ALUOP_PASSB: ctrl = ALU_PASSB;
      ALUOP_BRANCH: begin
        case (fn3)
          3'b000, 3'b001: ctrl = ALU_SUB;
          3'b100, 3'b101: ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl = ALU_SLTU;
          default:        ctrl = ALU_ADD;
        endcase
      end
      default: begin
        if (!is_md) begin
          case (fn3)
            3'b000:  ctrl = (opcode[5] && fn7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = fn7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
          endcase
        end
      end
    endcase
  end

  assign alu_ctrl = CTRL_W'(ctrl);

  // the accept-cycle stall is combinational so IF/ID hold before the engine leaves IDLE
  assign accept = ex_valid & is_md & ~flush & core_idle;
  assign stall  = ~rst & (accept | (core_calc & ~flush));

  md_iter_core #(
    .WIDTH (WIDTH),
    .STEPS (STEPS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .flush  (flush),
    .op     (md_op_e'(fn3)),
    .a      (src_a),
    .b      (src_b),
    .idle   (core_idle),
    .calc   (core_calc),
    .done   (md_done),
    .result (md_result)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_decode_md.sv
// tb_alu_decode_md: decode table, directed RV32M corner cases and randomized ops vs. an arithmetic model.
`default_nettype none

module tb_alu_decode_md;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   aluop    [2];
  logic [6:0]   opcode   [2];
  logic [2:0]   fn3      [2];
  logic [6:0]   fn7      [2];
  logic         ex_valid [2];
  logic         flush    [2];
  logic [W-1:0] src_a    [2];
  logic [W-1:0] src_b    [2];
  logic [3:0]   alu_ctrl [2];
  logic         is_md    [2];
  logic         stall    [2];
  logic         md_done  [2];
  logic [W-1:0] md_result[2];

  alu_decode_md #(.WIDTH(W), .STEPS(1), .CTRL_W(4)) dut_s1 (
    .clk(clk), .rst(rst), .ALUOp(aluop[0]), .opcode(opcode[0]), .fn3(fn3[0]), .fn7(fn7[0]),
    .ex_valid(ex_valid[0]), .flush(flush[0]), .src_a(src_a[0]), .src_b(src_b[0]),
    .alu_ctrl(alu_ctrl[0]), .is_md(is_md[0]), .stall(stall[0]), .md_done(md_done[0]),
    .md_result(md_result[0]));

  alu_decode_md #(.WIDTH(W), .STEPS(4), .CTRL_W(4)) dut_s4 (
    .clk(clk), .rst(rst), .ALUOp(aluop[1]), .opcode(opcode[1]), .fn3(fn3[1]), .fn7(fn7[1]),
    .ex_valid(ex_valid[1]), .flush(flush[1]), .src_a(src_a[1]), .src_b(src_b[1]),
    .alu_ctrl(alu_ctrl[1]), .is_md(is_md[1]), .stall(stall[1]), .md_done(md_done[1]),
    .md_result(md_result[1]));

  int passed = 0;
  int total  = 0;
  logic [W-1:0] last_res [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stalls(input int s, input logic [2:0] op, input logic [31:0] b, input logic [31:0] a);
    bit quick;
    quick = (op >= 3'd4) && ((b == 0) ||
            ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return quick ? 1 : 1 + 32 / ((s == 0) ? 1 : 4);
  endfunction

  task automatic drive_md(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    aluop[s] = 2'b10; opcode[s] = 7'h33; fn7[s] = 7'h01; fn3[s] = op;
    src_a[s] = a; src_b[s] = b; ex_valid[s] = 1'b1;
  endtask

  task automatic idle_inputs(input int s);
    aluop[s] = 2'b00; opcode[s] = 7'h00; fn7[s] = 7'h00; fn3[s] = 3'b000;
    ex_valid[s] = 1'b0; flush[s] = 1'b0; src_a[s] = '0; src_b[s] = '0;
  endtask

  // called just after a rising edge; returns just after the rising edge ending the DONE cycle
  task automatic run_md(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int stalls = 0;
    bit seen = 0;
    logic [31:0] exp;
    exp = ref_md(op, a, b);
    drive_md(s, op, a, b);
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      if (md_done[s]) begin
        seen = 1;
        check($sformatf("%s_s%0d_result", tag, s), md_result[s], exp);
        check($sformatf("%s_s%0d_stall_in_done", tag, s), stall[s], 0);
      end else if (stall[s]) stalls++;
      @(posedge clk); #1;
    end
    idle_inputs(s);
    check($sformatf("%s_s%0d_done_seen", tag, s), seen, 1);
    check($sformatf("%s_s%0d_stall_cycles", tag, s), stalls, ref_stalls(s, op, b, a));
    last_res[s] = exp;
  endtask

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] ctrl;
    logic       md;
  } dec_t;

  dec_t dt[18];

  initial begin
    int bad;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    dt[0]  = '{2'b10, 7'h33, 3'b000, 7'h20, 4'd1,  1'b0};
    dt[1]  = '{2'b10, 7'h33, 3'b101, 7'h20, 4'd9,  1'b0};
    dt[2]  = '{2'b01, 7'h63, 3'b110, 7'h00, 4'd6,  1'b0};
    dt[3]  = '{2'b11, 7'h37, 3'b000, 7'h00, 4'd10, 1'b0};
    dt[4]  = '{2'b10, 7'h13, 3'b000, 7'h20, 4'd0,  1'b0};
    dt[5]  = '{2'b10, 7'h13, 3'b101, 7'h20, 4'd9,  1'b0};
    dt[6]  = '{2'b10, 7'h33, 3'b101, 7'h00, 4'd8,  1'b0};
    dt[7]  = '{2'b10, 7'h33, 3'b001, 7'h00, 4'd4,  1'b0};
    dt[8]  = '{2'b10, 7'h33, 3'b010, 7'h00, 4'd5,  1'b0};
    dt[9]  = '{2'b10, 7'h33, 3'b011, 7'h00, 4'd6,  1'b0};
    dt[10] = '{2'b10, 7'h33, 3'b100, 7'h00, 4'd7,  1'b0};
    dt[11] = '{2'b10, 7'h33, 3'b110, 7'h00, 4'd3,  1'b0};
    dt[12] = '{2'b10, 7'h33, 3'b111, 7'h00, 4'd2,  1'b0};
    dt[13] = '{2'b00, 7'h03, 3'b010, 7'h00, 4'd0,  1'b0};
    dt[14] = '{2'b01, 7'h63, 3'b001, 7'h00, 4'd1,  1'b0};
    dt[15] = '{2'b01, 7'h63, 3'b101, 7'h00, 4'd5,  1'b0};
    dt[16] = '{2'b01, 7'h63, 3'b010, 7'h00, 4'd0,  1'b0};
    dt[17] = '{2'b10, 7'h33, 3'b110, 7'h01, 4'd0,  1'b1};

    for (int s = 0; s < 2; s++) begin
      idle_inputs(s);
      last_res[s] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_stall_s%0d", s), stall[s], 0);
      check($sformatf("reset_done_s%0d", s), md_done[s], 0);
      check($sformatf("reset_result_s%0d", s), md_result[s], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // combinational decode sweep with ex_valid low
    for (int i = 0; i < 18; i++) begin
      aluop[0] = dt[i].aluop; opcode[0] = dt[i].opc; fn3[0] = dt[i].f3; fn7[0] = dt[i].f7;
      #2;
      check($sformatf("decode%0d_ctrl", i), alu_ctrl[0], dt[i].ctrl);
      check($sformatf("decode%0d_is_md", i), is_md[0], dt[i].md);
      check($sformatf("decode%0d_stall", i), stall[0], 0);
    end
    idle_inputs(0);
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      run_md(s, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
      run_md(s, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
      run_md(s, 3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_md(s, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_md(s, 3'd5, 32'd100, 32'd0, "divu_by0");
      run_md(s, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_md(s, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_md(s, 3'd0, 32'd5, 32'd6, "b2b_mul");
      run_md(s, 3'd5, 32'd30, 32'd4, "b2b_divu");
    end

    // flush together with a valid M op in IDLE: not accepted
    drive_md(0, 3'd0, 32'd3, 32'd4);
    flush[0] = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", stall[0], 0);
    @(posedge clk); #1;
    idle_inputs(0);
    @(negedge clk);
    check("flush_idle_no_calc", stall[0], 0);
    @(posedge clk); #1;

    // flush 10 cycles into a DIV
    drive_md(0, 3'd4, 32'hFFFF_FF9C, 32'd7);
    repeat (10) begin @(negedge clk); @(posedge clk); #1; end
    flush[0] = 1'b1;
    @(negedge clk);
    check("flush_calc_stall", stall[0], 0);
    check("flush_calc_done", md_done[0], 0);
    @(posedge clk); #1;
    idle_inputs(0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_done[0] || stall[0]) bad++;
    end
    check("flush_quiet_after", bad, 0);
    check("flush_result_held", md_result[0], last_res[0]);
    @(posedge clk); #1;
    run_md(0, 3'd0, 32'd3, 32'd4, "mul_after_flush");

    // reset in the middle of a multiply
    drive_md(0, 3'd0, 32'd9, 32'd9);
    repeat (5) begin @(negedge clk); @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall_forced", stall[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs(0);
    @(negedge clk);
    check("rst_mid_stall", stall[0], 0);
    check("rst_mid_done", md_done[0], 0);
    check("rst_mid_result", md_result[0], 0);
    check("rst_mid_ctrl", alu_ctrl[0], 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_done[0]) bad++;
    end
    check("rst_mid_no_done", bad, 0);
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 25; n++) begin
        rop = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       ra = 32'h8000_0000;
          1:       ra = 32'($urandom_range(0, 20)) - 32'd10;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0:       rb = 32'd0;
          1:       rb = 32'hFFFF_FFFF;
          2:       rb = 32'($urandom_range(0, 20)) - 32'd10;
          default: rb = $urandom;
        endcase
        run_md(s, rop, ra, rb, $sformatf("rand%0d_op%0d", n, rop));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
